mipi_packet_deframer: RTL and testbench

Parametrised receive-side deframer for the MIPI RX pixel stream. It hunts for the SOF marker, decodes the two-beat header (packet id, data type, length, peripheral id) and assembles exactly the advertised number of payload beats into a wide buffer. It then holds the frame under a valid/ack handshake until the consumer (miner job loader) accepts it. Over the existing single-mode receiver it adds beat qualification by VALID, exact beat counting, configurable beat width and buffer depth, optional half-swap, length/timeout/overrun error reporting and a frame counter.

---
 rtl/mipi_packet_deframer.sv | 185 ++++++++++++++++++
 tb/tb_mipi_packet_deframer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_packet_deframer.sv
// Receive-side MIPI deframer: hunts for SOF, decodes the two-beat header and assembles the
// advertised payload beats into a wide buffer held under a valid/ack handshake.
module mipi_packet_deframer #(
    parameter int unsigned BEAT_BYTES  = 6,
    parameter int unsigned MAX_BYTES   = 48,
    parameter logic [23:0] SOF         = 24'hEAFF99,
    parameter bit          SWAP_HALVES = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                    rx_pixel_clk,
    input  logic                    rx_rst,
    input  logic [BEAT_BYTES*8-1:0] packet,
    input  logic                    my_mipi_rx_VALID,
    input  logic                    data_ack,
    output logic [MAX_BYTES*8-1:0]  data,
    output logic                    data_available,
    output logic [23:0]             pkt_id,
    output logic [7:0]              dtype,
    output logic [31:0]             dlen,
    output logic [7:0]              phl_id,
    output logic                    err_len,
    output logic                    err_timeout,
    output logic                    err_overrun,
    output logic [15:0]             frame_count
);

    localparam int unsigned W         = BEAT_BYTES * 8;
    localparam int unsigned DW        = MAX_BYTES * 8;
    localparam int unsigned MAX_BEATS = MAX_BYTES / BEAT_BYTES;
    localparam int unsigned BL_W      = $clog2(MAX_BEATS + 1);
    localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHdr  = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StHold = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic            avail_q, avail_d;
    logic [23:0]     pkt_id_q, pkt_id_d;
    logic [7:0]      dtype_q, dtype_d;
    logic [31:0]     dlen_q, dlen_d;
    logic [7:0]      phl_id_q, phl_id_d;
    logic            err_len_q, err_len_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_overrun_q, err_overrun_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [BL_W-1:0] beats_left_q, beats_left_d;
    logic [15:0]     stall_q, stall_d;

    logic            sof_hit;
    logic [31:0]     hdr_dlen;
    logic [31:0]     beats_calc;
    logic [W-1:0]    beat_stored;

    assign sof_hit     = my_mipi_rx_VALID && (packet[W-1:W-24] == SOF);
    assign hdr_dlen    = packet[W-9:W-40];
    assign beats_calc  = (hdr_dlen + 32'(BEAT_BYTES - 1)) / 32'(BEAT_BYTES);
    assign beat_stored = SWAP_HALVES ? {packet[W/2-1:0], packet[W-1:W/2]} : packet;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        avail_d       = avail_q;
        pkt_id_d      = pkt_id_q;
        dtype_d       = dtype_q;
        dlen_d        = dlen_q;
        phl_id_d      = phl_id_q;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        frame_count_d = frame_count_q;
        beats_left_d  = beats_left_q;
        stall_d       = stall_q;

        case (state_q)
            StIdle: begin
                if (sof_hit) begin
                    pkt_id_d = packet[W-25:W-48];
                    stall_d  = '0;
                    state_d  = StHdr;
                end
            end
            StHdr: begin
                if (my_mipi_rx_VALID) begin
                    dtype_d  = packet[W-1:W-8];
                    dlen_d   = hdr_dlen;
                    phl_id_d = packet[W-41:W-48];
                    stall_d  = '0;
                    if (hdr_dlen == 32'd0 || hdr_dlen > 32'(MAX_BYTES)) begin
                        err_len_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        data_d       = '0;
                        beats_left_d = BL_W'(beats_calc);
                        state_d      = StData;
                    end
                end
            end
            StData: begin
                if (my_mipi_rx_VALID) begin
                    stall_d      = '0;
                    data_d       = (data_q << W) | DW'(beat_stored);
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == BL_W'(1)) begin
                        avail_d       = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = StHold;
                    end
                end
            end
            StHold: begin
                if (data_ack) begin
                    avail_d = 1'b0;
                    // Zero-bubble: an SOF in the ack cycle starts the next frame directly.
                    if (sof_hit) begin
                        pkt_id_d = packet[W-25:W-48];
                        stall_d  = '0;
                        state_d  = StHdr;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (sof_hit) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q == StHdr || state_q == StData) && !my_mipi_rx_VALID) begin
            if (stall_q == STALL_MAX) begin
                err_timeout_d = 1'b1;
                stall_d       = '0;
                state_d       = StIdle;
            end else begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge rx_pixel_clk) begin
        if (rx_rst) begin
            state_q       <= StIdle;
            data_q        <= '0;
            avail_q       <= 1'b0;
            pkt_id_q      <= '0;
            dtype_q       <= '0;
            dlen_q        <= '0;
            phl_id_q      <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            frame_count_q <= '0;
            beats_left_q  <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            avail_q       <= avail_d;
            pkt_id_q      <= pkt_id_d;
            dtype_q       <= dtype_d;
            dlen_q        <= dlen_d;
            phl_id_q      <= phl_id_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            frame_count_q <= frame_count_d;
            beats_left_q  <= beats_left_d;
            stall_q       <= stall_d;
        end
    end

    assign data           = data_q;
    assign data_available = avail_q;
    assign pkt_id         = pkt_id_q;
    assign dtype          = dtype_q;
    assign dlen           = dlen_q;
    assign phl_id         = phl_id_q;
    assign err_len        = err_len_q;
    assign err_timeout    = err_timeout_q;
    assign err_overrun    = err_overrun_q;
    assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_mipi_packet_deframer.sv
// Bench for mipi_packet_deframer: directed and randomized frames checked against expectations
// built from the frame contents the bench itself sends.
module tb_mipi_packet_deframer;

    localparam int W  = 48;
    localparam int DW = 384;
    localparam logic [23:0] SOF = 24'hEAFF99;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  packet;
    logic          valid;
    logic          ack;
    logic [DW-1:0] data;
    logic          data_available;
    logic [23:0]   pkt_id;
    logic [7:0]    dtype;
    logic [31:0]   dlen;
    logic [7:0]    phl_id;
    logic          err_len;
    logic          err_timeout;
    logic          err_overrun;
    logic [15:0]   frame_count;

    int checks = 0;
    int failures = 0;
    int exp_frames = 0;
    logic [DW-1:0] exp_data;
    logic [23:0]   exp_id;

    mipi_packet_deframer #(
        .BEAT_BYTES (6),
        .MAX_BYTES  (48),
        .SOF        (24'hEAFF99),
        .SWAP_HALVES(1'b1),
        .TIMEOUT    (4)
    ) dut (
        .rx_pixel_clk    (clk),
        .rx_rst          (rst),
        .packet          (packet),
        .my_mipi_rx_VALID(valid),
        .data_ack        (ack),
        .data            (data),
        .data_available  (data_available),
        .pkt_id          (pkt_id),
        .dtype           (dtype),
        .dlen            (dlen),
        .phl_id          (phl_id),
        .err_len         (err_len),
        .err_timeout     (err_timeout),
        .err_overrun     (err_overrun),
        .frame_count     (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] p, input logic v, input logic a);
        packet = p;
        valid  = v;
        ack    = a;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Never carries the SOF marker.
    function automatic logic [W-1:0] rand_plain();
        logic [W-1:0] b;
        b = rand_beat();
        b[W-1:W-8] = 8'h00;
        return b;
    endfunction

    function automatic logic rand_bit();
        int unsigned r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic logic [W-1:0] swap(input logic [W-1:0] b);
        return {b[W/2-1:0], b[W-1:W/2]};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, data, '0);
        chk({tag, "_avail"}, DW'(data_available), '0);
        chk({tag, "_pkt_id"}, DW'(pkt_id), '0);
        chk({tag, "_dtype"}, DW'(dtype), '0);
        chk({tag, "_dlen"}, DW'(dlen), '0);
        chk({tag, "_phl_id"}, DW'(phl_id), '0);
        chk({tag, "_err_len"}, DW'(err_len), '0);
        chk({tag, "_err_timeout"}, DW'(err_timeout), '0);
        chk({tag, "_err_overrun"}, DW'(err_overrun), '0);
        chk({tag, "_frame_count"}, DW'(frame_count), '0);
    endtask

    // Sends SOF, header and ceil(len/6) payload beats with gaps, then checks delivery.
    task automatic send_frame(input logic [31:0] len, input int max_gap, input bit fixed_gap,
                              input logic ack_first);
        logic [31:0]  r;
        logic [23:0]  id;
        logic [7:0]   dt;
        logic [7:0]   ph;
        logic [W-1:0] b;
        int           n;
        r  = $urandom;
        id = r[23:0];
        dt = r[31:24];
        r  = $urandom;
        ph = r[7:0];
        drive({SOF, id}, 1'b1, ack_first);
        chk("sof_avail_low", DW'(data_available), '0);
        drive({dt, len, ph}, 1'b1, rand_bit());
        chk("hdr_pkt_id", DW'(pkt_id), DW'(id));
        chk("hdr_dtype", DW'(dtype), DW'(dt));
        chk("hdr_dlen", DW'(dlen), DW'(len));
        chk("hdr_phl_id", DW'(phl_id), DW'(ph));
        chk("hdr_err_len", DW'(err_len), '0);
        n = int'((len + 32'd5) / 32'd6);
        exp_data = '0;
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = fixed_gap ? max_gap : int'($urandom_range(max_gap, 0));
            for (int g = 0; g < gaps; g++) begin
                drive(rand_beat(), 1'b0, rand_bit());
                chk("gap_avail", DW'(data_available), '0);
                chk("gap_timeout", DW'(err_timeout), '0);
            end
            b = rand_beat();
            exp_data[(n-1-i)*W +: W] = swap(b);
            drive(b, 1'b1, rand_bit());
            if (i < n - 1) chk("beat_avail_low", DW'(data_available), '0);
        end
        exp_frames++;
        exp_id = id;
        chk("deliver_avail", DW'(data_available), DW'(1'b1));
        chk("deliver_data", data, exp_data);
        chk("deliver_count", DW'(frame_count), DW'(16'(exp_frames)));
    endtask

    task automatic ack_frame();
        drive(rand_plain(), 1'b0, 1'b1);
        chk("ack_avail", DW'(data_available), '0);
    endtask

    initial begin
        logic [31:0] bad_len [3];
        bad_len = '{32'd0, 32'd49, 32'hFFFF_FFF0};

        // Reset with random activity
        rst = 1'b1;
        packet = '0;
        valid = 1'b0;
        ack = 1'b0;
        for (int i = 0; i < 3; i++) drive(rand_beat(), rand_bit(), rand_bit());
        chk_all_zero("reset");
        rst = 1'b0;

        // Nominal directed frame
        drive(48'hEAFF99_123456, 1'b1, 1'b0);
        drive({8'h01, 32'd12, 8'h07}, 1'b1, 1'b0);
        chk("nom_pkt_id", DW'(pkt_id), DW'(24'h123456));
        chk("nom_dtype", DW'(dtype), DW'(8'h01));
        chk("nom_dlen", DW'(dlen), DW'(32'd12));
        chk("nom_phl_id", DW'(phl_id), DW'(8'h07));
        drive(48'hAAAAAA_BBBBBB, 1'b1, 1'b0);
        chk("nom_avail_early", DW'(data_available), '0);
        drive(48'hCCCCCC_DDDDDD, 1'b1, 1'b0);
        exp_frames = 1;
        chk("nom_avail", DW'(data_available), DW'(1'b1));
        chk("nom_data", data, DW'(96'hBBBBBB_AAAAAA_DDDDDD_CCCCCC));
        chk("nom_count", DW'(frame_count), DW'(16'd1));
        drive(rand_plain(), 1'b1, 1'b0);
        chk("hold_frozen", data, DW'(96'hBBBBBB_AAAAAA_DDDDDD_CCCCCC));
        ack_frame();

        // Partial last beat with fixed 3-cycle gaps, then random frames and length bounds
        send_frame(32'd7, 3, 1'b1, 1'b0);
        ack_frame();
        for (int k = 0; k < 6; k++) begin
            send_frame(32'($urandom_range(48, 1)), 3, 1'b0, 1'b0);
            ack_frame();
        end
        send_frame(32'd48, 1, 1'b0, 1'b0);
        ack_frame();
        send_frame(32'd1, 0, 1'b0, 1'b0);
        ack_frame();

        // Length errors
        for (int k = 0; k < 3; k++) begin
            drive({SOF, 24'h0A0B0C}, 1'b1, 1'b0);
            drive({8'h55, bad_len[k], 8'h66}, 1'b1, 1'b0);
            chk("len_err_pulse", DW'(err_len), DW'(1'b1));
            chk("len_err_dlen", DW'(dlen), DW'(bad_len[k]));
            chk("len_err_avail", DW'(data_available), '0);
            drive(rand_plain(), 1'b1, 1'b0);
            chk("len_err_single", DW'(err_len), '0);
            chk("len_err_count", DW'(frame_count), DW'(16'(exp_frames)));
        end
        send_frame(32'd18, 2, 1'b0, 1'b0);
        ack_frame();

        // Timeout after one of two payload beats
        drive({SOF, 24'h777777}, 1'b1, 1'b0);
        drive({8'h01, 32'd12, 8'h02}, 1'b1, 1'b0);
        drive(rand_beat(), 1'b1, 1'b0);
        for (int g = 1; g <= 4; g++) begin
            drive(rand_beat(), 1'b0, 1'b0);
            chk("timeout_pulse", DW'(err_timeout), DW'(g == 4));
            chk("timeout_avail", DW'(data_available), '0);
        end
        drive(rand_plain(), 1'b1, 1'b0);
        chk("timeout_single", DW'(err_timeout), '0);
        chk("timeout_idle_avail", DW'(data_available), '0);
        send_frame(32'd12, 0, 1'b0, 1'b0);

        // Overrun while holding, then zero-bubble SOF on the ack cycle
        drive({SOF, 24'h424242}, 1'b1, 1'b0);
        chk("overrun_pulse", DW'(err_overrun), DW'(1'b1));
        chk("overrun_data", data, exp_data);
        chk("overrun_avail", DW'(data_available), DW'(1'b1));
        chk("overrun_pkt_id", DW'(pkt_id), DW'(exp_id));
        drive(rand_plain(), 1'b0, 1'b0);
        chk("overrun_single", DW'(err_overrun), '0);
        send_frame(32'($urandom_range(48, 1)), 1, 1'b0, 1'b1);
        ack_frame();

        // Reset mid-DATA
        drive({SOF, 24'h313131}, 1'b1, 1'b0);
        drive({8'h09, 32'd24, 8'h03}, 1'b1, 1'b0);
        drive(rand_beat(), 1'b1, 1'b0);
        rst = 1'b1;
        drive(rand_beat(), 1'b1, rand_bit());
        rst = 1'b0;
        chk_all_zero("rst_mid");
        drive(rand_plain(), 1'b0, 1'b0);
        chk_all_zero("post_rst");
        exp_frames = 0;
        send_frame(32'd6, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
